alu_frame_serializer: RTL and testbench
=======================================

Name: alu_frame_serializer

Overview:
- Synthesizable upstream stage that drives the serial ALU input line `sin`.
- Accepts one operation (B, A, op) per valid/ready handshake and computes its CRC-4.
- Emits the frame as N data packets plus one control packet, each 11 bits, MSB first.
- Optional fault injection (short frame, corrupted CRC) provokes the DUT's error responses so the downstream checker sees both DATA and CTL-only output frames.

Parameters:
- GAP, 2, minimum idle-high cycles on `sin` after a frame's last stop bit before the next frame may start (1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request holds a valid operation
- in_ready  out  1  block can accept an operation this cycle
- in_b  in  32  operand B, signed, sent first
- in_a  in  32  operand A, signed
- in_op  in  3  operation code, passed through unchecked
- in_nbytes  in  4  number of data packets to send; 8 is a legal frame; values 9..15 are treated as 8
- in_crc_bad  in  1  when 1, the transmitted CRC is the computed CRC XOR 4'b0001
- sin  out  1  serial line to the ALU; idles high
- busy  out  1  frame or gap in progress
- done  out  1  single-cycle pulse, asserted during the cycle the final stop bit is on `sin`

Behaviour:
- Reset (async, rst_n=0): sin=1, in_ready=0, busy=0, done=0; state=IDLE; all counters and holding registers cleared. After release, in_ready rises on the first clock edge.
- Reset mid-frame: sin returns to 1 immediately; the partial frame is abandoned and never resumed.
- Handshake: in_ready=1 only in IDLE. Accept on a rising edge with in_valid&in_ready. All inputs are captured into holding registers at accept; later input changes have no effect. in_ready drops on the accept edge.
- CRC-4 is computed at accept:
  - polynomial x^4+x+1, init 4'b0000;
  - runs over the 68-bit vector {B[31:0], A[31:0], 1'b1, op[2:0]}, bit 67 first;
  - parallel (combinational) form, registered at accept.
  - Reference value: B=0, A=0, op=0 gives CRC 4'b1011.
- Packet format, 11 bits in order: start 0, type bit, 8 payload bits MSB first, stop 1.
  - Data packets: type=0.
  - Control packet: type=1, payload {1'b0, op[2:0], crc[3:0]}.
- Byte order: B[31:24], B[23:16], B[15:8], B[7:0], A[31:24], A[23:16], A[15:8], A[7:0]. With N<8, only the first N bytes of this sequence are sent, then the control packet. The CRC always covers the full operands.
- Timing: the first start bit drives `sin` from the accept edge onward, so it is visible in the cycle after accept. Each bit is held exactly one cycle. Frame length is 11*(N+1) cycles; for N=0 only the control packet is sent.
- FSM:
  - IDLE -> SEND on accept.
  - SEND advances a bit counter (0..10) and a packet counter (0..N). When the control packet's stop bit completes: SEND -> GAP.
  - GAP counts GAP cycles with sin=1. GAP -> IDLE, and in_ready=1 in the cycle after the last gap cycle.
- busy=1 throughout SEND and GAP.
- done pulses once per frame, coincident with the final stop bit. It never pulses for an abandoned (reset) frame.
- The path from `sin` to the flop output is registered; no combinational path from inputs to `sin`.
- Back-to-back frames: minimum spacing from frame start to frame start is 11*(N+1)+GAP+1 cycles.

Test Plan:
- Reset then B=0, A=0, op=3'b000, N=8, crc_bad=0 -> 99-bit frame of 8 packets 0_0_00000000_1, then control packet 0_1_00001011_1; done on cycle 99 after accept; in_ready back after GAP+1 more cycles.
- B=32'h0102_0304, A=32'hFFFF_FFFF, N=8 -> data payloads 01,02,03,04,FF,FF,FF,FF in order; control payload CRC equals the serial x^4+x+1 model over {B,A,1,op}.
- Same operands with in_crc_bad=1 -> only the control packet's low nibble differs (bit0 inverted); all other bits are identical.
- N=3, B=32'hAABBCCDD -> payloads AA, BB, CC, then the control packet; frame is 44 cycles; done on cycle 44.
- in_nbytes=12 -> identical to N=8 (99-cycle frame).
- rst_n pulsed low at bit 40 of a frame -> sin=1 within the same cycle, no done pulse; the next accepted frame is emitted correctly from its start bit.

Source files
------------

// File: rtl/alu_frame_serializer.sv
// rtl/alu_frame_serializer.sv - serial frame generator driving the ALU input line
module alu_frame_serializer #(
    parameter int GAP = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_b,
    input  logic [31:0] in_a,
    input  logic [2:0]  in_op,
    input  logic [3:0]  in_nbytes,
    input  logic        in_crc_bad,
    output logic        sin,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] b_q, b_d;
    logic [31:0] a_q, a_d;
    logic [2:0]  op_q, op_d;
    logic [3:0]  n_q, n_d;
    logic [3:0]  crc_q, crc_d;
    logic [3:0]  bit_q, bit_d;
    logic [3:0]  pkt_q, pkt_d;
    logic [3:0]  gap_q, gap_d;
    logic        sin_q, sin_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;

    logic        accept;
    logic        is_ctl;
    logic [7:0]  data_byte;
    logic [7:0]  payload;
    logic [10:0] pkt_word;
    logic [3:0]  next_bit;

    // Serial x^4+x+1 LFSR unrolled over the whole vector; collapses to XOR trees.
    function automatic logic [3:0] crc4(input logic [67:0] v);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ v[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    assign accept = in_valid & ready_q;

    always_comb begin
        data_byte = 8'h00;
        case (pkt_q[2:0])
            3'd0: data_byte = b_q[31:24];
            3'd1: data_byte = b_q[23:16];
            3'd2: data_byte = b_q[15:8];
            3'd3: data_byte = b_q[7:0];
            3'd4: data_byte = a_q[31:24];
            3'd5: data_byte = a_q[23:16];
            3'd6: data_byte = a_q[15:8];
            default: data_byte = a_q[7:0];
        endcase
    end

    assign is_ctl   = (pkt_q == n_q);
    assign payload  = is_ctl ? {1'b0, op_q, crc_q} : data_byte;
    assign pkt_word = {1'b0, is_ctl, payload, 1'b1};
    assign next_bit = 4'(bit_q + 4'd1);

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        a_d     = a_q;
        op_d    = op_q;
        n_d     = n_q;
        crc_d   = crc_q;
        bit_d   = bit_q;
        pkt_d   = pkt_q;
        gap_d   = gap_q;
        sin_d   = 1'b1;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SEND;
                    b_d     = in_b;
                    a_d     = in_a;
                    op_d    = in_op;
                    n_d     = in_nbytes[3] ? 4'd8 : in_nbytes;
                    crc_d   = crc4({in_b, in_a, 1'b1, in_op}) ^ {3'b000, in_crc_bad};
                    bit_d   = 4'd0;
                    pkt_d   = 4'd0;
                    sin_d   = 1'b0;
                end
            end
            S_SEND: begin
                if (bit_q == 4'd10) begin
                    if (is_ctl) begin
                        state_d = S_GAP;
                        gap_d   = 4'd0;
                    end else begin
                        pkt_d = 4'(pkt_q + 4'd1);
                        bit_d = 4'd0;
                        sin_d = 1'b0;
                    end
                end else begin
                    bit_d  = next_bit;
                    // bit index k sits at pkt_word[10-k]
                    sin_d  = pkt_word[4'd9 - bit_q];
                    done_d = is_ctl && (bit_q == 4'd9);
                end
            end
            S_GAP: begin
                if (gap_q == 4'(GAP - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = 4'(gap_q + 4'd1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            b_q     <= '0;
            a_q     <= '0;
            op_q    <= '0;
            n_q     <= '0;
            crc_q   <= '0;
            bit_q   <= '0;
            pkt_q   <= '0;
            gap_q   <= '0;
            sin_q   <= 1'b1;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            a_q     <= a_d;
            op_q    <= op_d;
            n_q     <= n_d;
            crc_q   <= crc_d;
            bit_q   <= bit_d;
            pkt_q   <= pkt_d;
            gap_q   <= gap_d;
            sin_q   <= sin_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign sin      = sin_q;
    assign done     = done_q;
    assign in_ready = ready_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_frame_serializer.sv
// tb/tb_alu_frame_serializer.sv - directed vector bench for alu_frame_serializer
module tb_alu_frame_serializer;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_b = '0;
    logic [31:0] in_a = '0;
    logic [2:0]  in_op = '0;
    logic [3:0]  in_nbytes = '0;
    logic        in_crc_bad = 1'b0;
    logic        sin;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    alu_frame_serializer #(.GAP(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_b       (in_b),
        .in_a       (in_a),
        .in_op      (in_op),
        .in_nbytes  (in_nbytes),
        .in_crc_bad (in_crc_bad),
        .sin        (sin),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] b;
        logic [31:0] a;
        logic [2:0]  op;
        logic [3:0]  nb;
        logic        bad;
        int          exp_len;
        logic [8:0]  exp_ctl;   // bit 8 set: payload hand-known
    } vec_t;

    vec_t        vecs[6];
    logic [98:0] frames[6];
    logic [98:0] cap;

    task automatic chk(input string nm, input logic [98:0] got, input logic [98:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [3:0] crc_model(input logic [67:0] v);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ v[i];
            c  = {c[2:0], 1'b0};
            if (fb) c = c ^ 4'b0011;
        end
        return c;
    endfunction

    function automatic logic [10:0] exp_packet(input vec_t v, input int p);
        logic [63:0] w;
        logic [7:0]  pl;
        int          n;
        logic [3:0]  c;
        logic        ctl;
        n   = (v.nb > 4'd8) ? 8 : int'(v.nb);
        w   = {v.b, v.a};
        ctl = (p == n);
        if (ctl) begin
            c  = crc_model({v.b, v.a, 1'b1, v.op}) ^ {3'b000, v.bad};
            pl = {1'b0, v.op, c};
        end else begin
            w  = w >> (56 - 8 * p);
            pl = w[7:0];
        end
        // index 0 = first bit on the line
        return {1'b1, pl[0], pl[1], pl[2], pl[3], pl[4], pl[5], pl[6], pl[7], ctl, 1'b0};
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 300; i++) begin
            if (in_ready) return;
            @(negedge clk);
        end
        chk("ready_timeout", 99'(in_ready), 99'(1));
    endtask

    task automatic start_frame(input vec_t v);
        wait_ready();
        in_b = v.b; in_a = v.a; in_op = v.op; in_nbytes = v.nb; in_crc_bad = v.bad;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_b = ~v.b; in_a = ~v.a; in_op = ~v.op; in_nbytes = 4'd1; in_crc_bad = ~v.bad;
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int   len, n, ndone, done_at, rdy_at;
        logic busy_ok, gap_ok;
        logic [10:0] got_pk, exp_pk;
        n = (v.nb > 4'd8) ? 8 : int'(v.nb);
        len = 11 * (n + 1);
        start_frame(v);
        cap = '0; ndone = 0; done_at = 0; busy_ok = 1'b1; gap_ok = 1'b1; rdy_at = 0;
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            cap[c-1] = sin;
            if (done) begin ndone++; done_at = c; end
            if (!busy || in_ready) busy_ok = 1'b0;
        end
        for (int c = len + 1; c <= len + GAP + 4; c++) begin
            @(negedge clk);
            if (in_ready) begin rdy_at = c; break; end
            if (!sin || !busy || done) gap_ok = 1'b0;
        end
        frames[idx] = cap;
        chk($sformatf("v%0d_frame_len", idx), 99'(len), 99'(v.exp_len));
        chk($sformatf("v%0d_done_cycle", idx), 99'(done_at), 99'(v.exp_len));
        chk($sformatf("v%0d_done_count", idx), 99'(ndone), 99'(1));
        chk($sformatf("v%0d_busy", idx), 99'(busy_ok), 99'(1));
        chk($sformatf("v%0d_gap_idle", idx), 99'(gap_ok), 99'(1));
        chk($sformatf("v%0d_ready_cycle", idx), 99'(rdy_at), 99'(len + GAP + 1));
        for (int p = 0; p <= n; p++) begin
            got_pk = cap[11*p +: 11];
            exp_pk = exp_packet(v, p);
            chk($sformatf("v%0d_pkt%0d", idx, p), 99'(got_pk), 99'(exp_pk));
        end
        if (v.exp_ctl[8]) begin
            got_pk = cap[11*n +: 11];
            chk($sformatf("v%0d_ctl_payload", idx),
                99'({got_pk[2], got_pk[3], got_pk[4], got_pk[5], got_pk[6], got_pk[7], got_pk[8], got_pk[9]}),
                99'(v.exp_ctl[7:0]));
        end
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 3'b000, 4'd8,  1'b0, 99, 9'h10B};
        vecs[1] = '{32'h0102_0304, 32'hFFFF_FFFF, 3'b101, 4'd8,  1'b0, 99, 9'h000};
        vecs[2] = '{32'h0102_0304, 32'hFFFF_FFFF, 3'b101, 4'd8,  1'b1, 99, 9'h000};
        vecs[3] = '{32'hAABB_CCDD, 32'h1234_5678, 3'b010, 4'd3,  1'b0, 44, 9'h000};
        vecs[4] = '{32'h0102_0304, 32'hFFFF_FFFF, 3'b101, 4'd12, 1'b0, 99, 9'h000};
        vecs[5] = '{32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b111, 4'd0,  1'b0, 11, 9'h000};

        #12;
        chk("reset_sin", 99'(sin), 99'(1));
        chk("reset_ready", 99'(in_ready), 99'(0));
        chk("reset_busy_done", 99'({busy, done}), 99'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 99'(in_ready), 99'(1));

        for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

        chk("crcbad_only_bit0", frames[2] ^ frames[1], 99'(1) << 97);
        chk("nbytes12_eq_8", frames[4], frames[1]);

        // abandon a frame at bit 40 (a payload 0 bit) with an async reset
        begin
            int   nd;
            start_frame(vecs[0]);
            nd = 0;
            for (int c = 1; c <= 41; c++) begin
                @(negedge clk);
                if (done) nd++;
            end
            chk("midrst_bit40_low", 99'(sin), 99'(0));
            #2 rst_n = 1'b0;
            #1;
            chk("midrst_sin_high", 99'(sin), 99'(1));
            chk("midrst_idle", 99'({busy, in_ready}), 99'(0));
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (done || !sin) nd++;
            end
            rst_n = 1'b1;
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                if (done || !sin) nd++;
            end
            chk("midrst_no_done", 99'(nd), 99'(0));
            chk("midrst_ready", 99'(in_ready), 99'(1));
            run_frame(vecs[0], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
